// File: rtl/serial_deserializer_pkg.sv
// ---------------------------------------------------------------------------
// serial_deserializer_pkg
//
// Shared definitions for the receive side of the board's serial shift link.
// The transmit shift register frames words with the same encodings. Keep the
// two sides in step when anything here changes.
//
// Contents:
//   ds_state_t   receive FSM states (IDLE=0, SHIFT=1, STOP=2)
//   START_BIT    line level that opens a frame (0)
//   STOP_BIT     line level that closes a good frame (1)
//   cnt_width()  bit-counter width for a given data width, never below 1
// ---------------------------------------------------------------------------
package serial_deserializer_pkg;

  // Frame states. The encodings are fixed so that debug probes and the
  // transmit side can agree on the numeric values.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } ds_state_t;

  // Line levels for the framing bits. The line idles at the stop level, so
  // the first low sample on a tick marks the start of a frame.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Counter width needed to count WIDTH data bits (0 .. WIDTH-1).
  // $clog2(2) is 1, but we clamp anyway so that a degenerate width never
  // produces a zero-width vector.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_deserializer_bit_counter.sv
// ---------------------------------------------------------------------------
// ds_bit_counter
//
// Counts data bits within one received frame. It is cleared when a start bit
// is seen and advanced once per sampled data bit. tc flags the last data bit
// so the FSM can move on to the stop bit on that same tick.
//
// Ports:
//   DS_CLK  in   system clock, rising edge
//   DS_CLR  in   asynchronous active-high reset, clears the count
//   clr     in   synchronous clear (start of a new frame), wins over en
//   en      in   advance the count by one
//   tc      out  terminal count: count == WIDTH-1
// ---------------------------------------------------------------------------
module ds_bit_counter
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic DS_CLK,
  input  logic DS_CLR,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // Bit count for the frame in progress. It wraps back to zero after the
  // last data bit. For widths that are not a power of two, this keeps the
  // count inside 0 .. WIDTH-1 even if en were held longer than one frame.
  always_ff @(posedge DS_CLK or posedge DS_CLR) begin
    if (DS_CLR) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  assign tc = (cnt == LAST);

endmodule

// File: rtl/serial_deserializer.sv
// ---------------------------------------------------------------------------
// serial_deserializer
//
// Receive end of the board's serial shift link. The line is sampled only on
// bit_en ticks from the clock-divider mux. There is no oversampling, because
// ser_in is already synchronous to DS_CLK. Each frame is
//   start(0) + WIDTH data bits + stop(1)
// and a good frame is presented on data_out with a valid/ack handshake for
// the LED bank or the 7-seg driver.
//
// Parameters:
//   WIDTH      data bits per frame (>= 2)
//   MSB_FIRST  1: first data bit ends up in bit WIDTH-1
//              0: first data bit ends up in bit 0
//
// Ports:
//   DS_CLK      in   system clock, all state on the rising edge
//   DS_CLR      in   asynchronous active-high reset
//   bit_en      in   1-cycle sample tick
//   ser_in      in   serial data line, idles high
//   rd_ack      in   consumer has taken data_out (1-cycle pulse)
//   data_out    out  last good received word
//   data_valid  out  data_out holds an unread word
//   busy        out  frame in progress (state != IDLE)
//   frame_err   out  1-cycle pulse: stop bit sampled low
//   overrun     out  sticky: a word completed while data_valid was still set
// ---------------------------------------------------------------------------
module serial_deserializer
  import serial_deserializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             DS_CLK,
  input  logic             DS_CLR,
  input  logic             bit_en,
  input  logic             ser_in,
  input  logic             rd_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  ds_state_t        state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             cnt_clr;
  logic             cnt_en;
  logic             last_bit;

  // Shift direction is fixed at elaboration time. In MSB-first mode the
  // first bit received migrates up to bit WIDTH-1 after WIDTH shifts. In
  // LSB-first mode it migrates down to bit 0.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_next = {shreg[WIDTH-2:0], ser_in};
    end else begin : g_lsb_first
      assign shreg_next = {ser_in, shreg[WIDTH-1:1]};
    end
  endgenerate

  // Counter controls. The counter is cleared on the start-bit tick, so it
  // reads 0 when the first data bit arrives. It then steps once per data
  // tick while we are in SHIFT.
  assign cnt_clr = bit_en && (state == IDLE) && (ser_in == START_BIT);
  assign cnt_en  = bit_en && (state == SHIFT);

  ds_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .DS_CLK (DS_CLK),
    .DS_CLR (DS_CLR),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .tc     (last_bit)
  );

  // Frame FSM, shift register, output word and handshake flags in one
  // block, so every output is registered alongside the state that causes
  // it.
  //
  // Handshake priority: rd_ack clears data_valid first, then a good stop
  // tick in the same cycle sets it again. The consumer has taken the old
  // word, so the new word is simply pending, and overrun is only raised
  // when the old word was never acknowledged.
  //
  // A bad stop bit leaves data_out and data_valid untouched, so a pending
  // good word is not lost to a corrupted follow-on frame.
  //
  // STOP always returns to IDLE. The very next tick can therefore be the
  // start bit of a back-to-back frame.
  always_ff @(posedge DS_CLK or posedge DS_CLR) begin
    if (DS_CLR) begin
      state      <= IDLE;
      shreg      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      if (rd_ack) begin
        data_valid <= 1'b0;
      end
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (ser_in == START_BIT) begin
              state <= SHIFT;
            end
          end
          SHIFT: begin
            shreg <= shreg_next;
            if (last_bit) begin
              state <= STOP;
            end
          end
          STOP: begin
            if (ser_in == STOP_BIT) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              if (data_valid && !rd_ack) begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // busy is decoded from the registered state, so it stays glitch-free for
  // anything downstream that samples it on DS_CLK.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_deserializer.sv
// ---------------------------------------------------------------------------
// tb_serial_deserializer
//
// Drives one bitstream into two instances at the same time: one MSB-first
// and one LSB-first. The LSB-first instance receives the bit-reversed word.
// Expected words are queued when a good stop bit is driven and checked once
// the stop tick has been taken.
// ---------------------------------------------------------------------------
module tb_serial_deserializer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       bitEn = 1'b0;
  logic       serIn = 1'b1;
  logic       rdAck = 1'b0;

  logic [7:0] msbData;
  logic       msbValid;
  logic       msbBusy;
  logic       msbFrameErr;
  logic       msbOverrun;
  logic [7:0] lsbData;
  logic       lsbValid;
  logic       lsbBusy;
  logic       lsbFrameErr;
  logic       lsbOverrun;

  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] expMsbQ[$];
  logic [7:0] expLsbQ[$];

  // Free-running 100 MHz-style clock; inputs change on the falling edge.
  always #5 clock = ~clock;

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dutMsb (
    .DS_CLK     (clock),
    .DS_CLR     (reset),
    .bit_en     (bitEn),
    .ser_in     (serIn),
    .rd_ack     (rdAck),
    .data_out   (msbData),
    .data_valid (msbValid),
    .busy       (msbBusy),
    .frame_err  (msbFrameErr),
    .overrun    (msbOverrun)
  );

  serial_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dutLsb (
    .DS_CLK     (clock),
    .DS_CLR     (reset),
    .bit_en     (bitEn),
    .ser_in     (serIn),
    .rd_ack     (rdAck),
    .data_out   (lsbData),
    .data_valid (lsbValid),
    .busy       (lsbBusy),
    .frame_err  (lsbFrameErr),
    .overrun    (lsbOverrun)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Bit-reversal model for the LSB-first receiver.
  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7-i];
    end
    return r;
  endfunction

  // One sample tick: bit_en is high for exactly one rising edge.
  task automatic tick(input logic b, input logic ack);
    @(negedge clock);
    serIn = b;
    bitEn = 1'b1;
    rdAck = ack;
    @(negedge clock);
    bitEn = 1'b0;
    rdAck = 1'b0;
    serIn = 1'b1;
  endtask

  task automatic applyReset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic acknowledge();
    @(negedge clock);
    rdAck = 1'b1;
    @(negedge clock);
    rdAck = 1'b0;
    checkOutput("msb_valid_after_ack", 32'(msbValid), 0);
    checkOutput("lsb_valid_after_ack", 32'(lsbValid), 0);
  endtask

  // Sends one frame. stream[7] goes on the line first. A good stop bit
  // queues the expected words, which are popped and compared after the
  // stop tick. A bad stop bit expects a single-cycle frame_err pulse.
  task automatic applyStimulus(input logic [7:0] stream, input logic stopBit,
                               input logic ackOnStop);
    logic [7:0] expMsb;
    logic [7:0] expLsb;
    tick(1'b0, 1'b0);
    checkOutput("busy_after_start", 32'(msbBusy), 1);
    for (int i = 7; i >= 0; i--) begin
      tick(stream[i], 1'b0);
    end
    if (stopBit) begin
      expMsbQ.push_back(stream);
      expLsbQ.push_back(rev8(stream));
    end
    tick(stopBit, ackOnStop);
    checkOutput("msb_busy_after_stop", 32'(msbBusy), 0);
    checkOutput("lsb_busy_after_stop", 32'(lsbBusy), 0);
    if (stopBit) begin
      expMsb = expMsbQ.pop_front();
      expLsb = expLsbQ.pop_front();
      checkOutput("msb_data", 32'(msbData), 32'(expMsb));
      checkOutput("lsb_data", 32'(lsbData), 32'(expLsb));
      checkOutput("msb_valid", 32'(msbValid), 1);
      checkOutput("lsb_valid", 32'(lsbValid), 1);
      checkOutput("msb_frame_err_good", 32'(msbFrameErr), 0);
    end else begin
      checkOutput("msb_frame_err_pulse", 32'(msbFrameErr), 1);
      checkOutput("lsb_frame_err_pulse", 32'(lsbFrameErr), 1);
      @(negedge clock);
      checkOutput("msb_frame_err_drop", 32'(msbFrameErr), 0);
      checkOutput("lsb_frame_err_drop", 32'(lsbFrameErr), 0);
    end
  endtask

  // Hard time limit so a stuck run still ends with a visible failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting serial_deserializer bench");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    checkOutput("reset_data", 32'(msbData), 0);
    checkOutput("reset_valid", 32'(msbValid), 0);
    checkOutput("reset_busy", 32'(msbBusy), 0);
    checkOutput("reset_frame_err", 32'(msbFrameErr), 0);
    checkOutput("reset_overrun", 32'(msbOverrun), 0);

    // A5 (palindrome under bit reversal), then an LSB-first 01
    applyStimulus(8'hA5, 1'b1, 1'b0);
    acknowledge();
    applyStimulus(8'h80, 1'b1, 1'b0);
    acknowledge();

    // Bad stop bit after reset: output untouched
    applyReset();
    applyStimulus(8'h3C, 1'b0, 1'b0);
    checkOutput("ferr_msb_valid", 32'(msbValid), 0);
    checkOutput("ferr_msb_data", 32'(msbData), 0);
    checkOutput("ferr_lsb_data", 32'(lsbData), 0);

    // Overrun on unacknowledged back-to-back words
    applyReset();
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    checkOutput("ovr_msb_overrun", 32'(msbOverrun), 1);
    checkOutput("ovr_lsb_overrun", 32'(lsbOverrun), 1);
    repeat (3) @(negedge clock);
    checkOutput("ovr_sticky", 32'(msbOverrun), 1);

    // Same pair with rd_ack on the second stop tick: no overrun
    applyReset();
    checkOutput("ovr_cleared_by_reset", 32'(msbOverrun), 0);
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b1);
    checkOutput("ack_msb_overrun", 32'(msbOverrun), 0);
    checkOutput("ack_lsb_overrun", 32'(lsbOverrun), 0);

    // Reset in the middle of a frame, then a clean F0
    applyReset();
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b0);
    end
    checkOutput("abort_busy_before", 32'(msbBusy), 1);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy_async", 32'(msbBusy), 0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(8'hF0, 1'b1, 1'b0);
    acknowledge();

    // Line low without ticks: the receiver must stay idle
    @(negedge clock);
    serIn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (i % 5 == 4) begin
        checkOutput("gated_busy", 32'(msbBusy), 0);
      end
    end
    serIn = 1'b1;
    tick(1'b1, 1'b0);
    checkOutput("idle_tick_busy", 32'(msbBusy), 0);
    applyStimulus(8'h5A, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
